signed_comb: RTL and testbench
==============================

Name: signed_comb

Overview:
- Streaming signed comb (differentiator) stage: y[n] = x[n] - x[n-DELAY].
- Inverse of the running-sum/adder path; used as the decimating-side comb section of CIC chains and as a standalone first-difference filter.
- Sits between sample producers and consumers with a valid/ready handshake and a registered output.
- Bit growth of one bit is carried through.

Parameters:
- IWIDTH, 16, input sample width (signed two's complement), 2..32.
- DELAY, 1, differential delay in accepted samples, 1..16.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_data  input  IWIDTH  signed input sample.
- i_valid  input  1  i_data valid this cycle.
- o_ready  output  1  block can accept a sample this cycle.
- o_data  output  IWIDTH+1  signed difference x[n]-x[n-DELAY].
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_primed  output  1  high once DELAY samples have been accepted since reset; outputs are true differences from then on.

Behaviour:
- Reset (i_rst_n=0 sampled at edge):
  - o_data=0, o_valid=0, o_primed=0.
  - Delay line cleared to all zeros; fill counter cleared to 0.
  - Reset takes priority over every other event, including a mid-stream transfer; a pending o_data is discarded.
- Handshake:
  - o_ready = !o_valid || i_ready (combinational; one-deep output register, no skid buffer).
  - Input accept = i_valid && o_ready.
  - Output transfer = o_valid && i_ready.
- On accept:
  - o_data <= sext(i_data) - sext(dly[DELAY-1]), computed at IWIDTH+1 bits. This cannot overflow.
  - The delay line shifts: dly[0] <= i_data, dly[k] <= dly[k-1].
  - o_valid <= 1.
- Output transfer without accept: o_valid <= 0.
- Simultaneous output transfer and accept: o_valid stays 1 and o_data is replaced. Full throughput is one sample per clock.
- Stall (o_valid=1, i_ready=0):
  - o_data, o_valid and the delay line hold.
  - o_ready=0, so i_data is ignored even when i_valid=1.
- Latency: one clock from accept to o_valid with the corresponding result.
- Delay line behaviour:
  - Advances only on accept, so DELAY counts samples, not clocks.
  - Idle cycles do not age the history.
- Fill counter:
  - Increments on each accept and saturates at DELAY.
  - o_primed <= 1 on the accept that brings the count to DELAY. It is registered and aligns with that sample's o_valid, and stays 1 until reset.
- Before priming, the missing history reads as zero. The first DELAY outputs therefore equal sext(x[n]); this is intentional.
- Boundary cases:
  - Most negative minus most positive gives -(2^IWIDTH)+1, representable.
  - Most positive minus most negative gives 2^IWIDTH-1, representable.
- No state machine beyond the fill counter. The output register and the delay line are the only other storage.

Optional Feature:
- Macro: SIGNED_COMB_SAT_EN
- Defined: the difference is clamped to the IWIDTH signed range [-(2^(IWIDTH-1)), 2^(IWIDTH-1)-1] and then sign-extended onto o_data. A registered 1-bit output o_sat is added, high alongside o_valid when clamping occurred on that sample. o_sat resets to 0 and holds during a stall.
- Not defined: full IWIDTH+1 result, no clamping, no o_sat port.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset, then IWIDTH=16, DELAY=1, i_ready=1, stream 10, 25, 5 -> o_data 10, 15, -20, each one clock after accept; o_primed=1 from the first output.
- DELAY=3, stream 1, 2, 3, 4, 5, 6 -> o_data 1, 2, 3, 3, 3, 3; o_primed rises with the third output.
- Extremes, DELAY=1: 32767 then -32768 -> second o_data = -65535. -32768 then 32767 -> second o_data = 65535. With SIGNED_COMB_SAT_EN defined: -32768 and 32767 respectively, o_sat=1.
- Backpressure: hold i_ready=0 for 4 cycles while i_valid=1 with 7, 9 -> o_ready=0, o_data frozen at the first result (7), sample 9 not consumed. On i_ready=1, 9 is accepted and o_data=2.
- Gaps: DELAY=2 with i_valid toggling 1,0,0,1,0,1 carrying 4, 6, 10 -> o_data 4, 6, 6; idle cycles do not shift history.
- Reset mid-stream: after 5 samples assert i_rst_n=0 for 1 cycle while o_valid=1 -> o_valid=0, o_primed=0. The next input 8 with DELAY=1 gives o_data=8.

Source files
------------

// File: rtl/signed_comb.sv
// -----------------------------------------------------------------------------
// signed_comb
//   Streaming signed comb (differentiator) stage: y[n] = x[n] - x[n-DELAY].
//   The delay line advances only on accepted samples, so DELAY counts samples,
//   not clocks. The result carries one bit of growth (IWIDTH+1 bits) and is
//   held in a one-deep output register behind a valid/ready handshake.
//
// Parameters
//   IWIDTH  input sample width, signed two's complement (2..32)
//   DELAY   differential delay in accepted samples (1..16)
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   synchronous active-low reset
//   i_data    signed input sample            (IWIDTH)
//   i_valid   i_data valid this cycle
//   o_ready   block can accept a sample this cycle
//   o_data    signed difference              (IWIDTH+1)
//   o_valid   o_data valid
//   i_ready   downstream accepts o_data this cycle
//   o_sat     (SIGNED_COMB_SAT_EN only) clamping happened on this o_data
//   o_primed  DELAY samples have been accepted since reset
//
// Build option
//   SIGNED_COMB_SAT_EN  when defined, the difference is clamped to the IWIDTH
//                       signed range, sign-extended onto o_data, and o_sat is
//                       added. Latency and handshake are unchanged.
// -----------------------------------------------------------------------------
module signed_comb #(
    parameter int IWIDTH = 16,
    parameter int DELAY  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IWIDTH-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [IWIDTH:0]   o_data,
    output logic              o_valid,
    input  logic              i_ready,
`ifdef SIGNED_COMB_SAT_EN
    output logic              o_sat,
`endif
    output logic              o_primed
);

    // Fill counter only needs to reach DELAY, then it sticks.
    localparam int            CW        = $clog2(DELAY + 1);
    localparam logic [CW-1:0] FILL_MAX  = CW'(DELAY);
    localparam logic [CW-1:0] FILL_LAST = CW'(DELAY - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [IWIDTH-1:0] dly_q [DELAY];
    logic [IWIDTH-1:0] dly_d [DELAY];
    logic [CW-1:0]     fill_q,   fill_d;
    logic              primed_q, primed_d;
    logic [IWIDTH:0]   data_q,   data_d;
    logic              valid_q,  valid_d;
`ifdef SIGNED_COMB_SAT_EN
    logic              sat_q,    sat_d;
`endif

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic accept;
    logic xfer;

    // One-deep output register: free slot, or the slot empties this cycle.
    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;
    assign xfer    = valid_q && i_ready;

    // -------------------------------------------------------------------------
    // Difference datapath
    // -------------------------------------------------------------------------
    logic [IWIDTH:0] diff_full;
    logic [IWIDTH:0] result;

    // Both operands are sign-extended by one bit first, so the subtraction
    // cannot overflow at IWIDTH+1 bits.
    assign diff_full = {i_data[IWIDTH-1], i_data}
                     - {dly_q[DELAY-1][IWIDTH-1], dly_q[DELAY-1]};

`ifdef SIGNED_COMB_SAT_EN
    logic overflow;

    // The value fits in IWIDTH signed bits exactly when the top two bits agree.
    assign overflow = diff_full[IWIDTH] ^ diff_full[IWIDTH-1];

    always_comb begin
        result = diff_full;
        if (overflow) begin
            // Sign bit of the wide result picks the rail to clamp to.
            result = diff_full[IWIDTH] ? {2'b11, {(IWIDTH-1){1'b0}}}
                                       : {2'b00, {(IWIDTH-1){1'b1}}};
        end
    end
`else
    assign result = diff_full;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        dly_d    = dly_q;
        fill_d   = fill_q;
        primed_d = primed_q;
        data_d   = data_q;
        valid_d  = valid_q;
`ifdef SIGNED_COMB_SAT_EN
        sat_d    = sat_q;
`endif

        if (accept) begin
            // History ages only on accepted samples; idle cycles leave it alone.
            dly_d[0] = i_data;
            for (int k = 1; k < DELAY; k++) begin
                dly_d[k] = dly_q[k-1];
            end

            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            // Registered so it rises together with this sample's o_valid.
            if (fill_q == FILL_LAST) begin
                primed_d = 1'b1;
            end

            // Also covers the simultaneous transfer+accept case: the slot
            // stays full and the data is replaced.
            data_d  = result;
            valid_d = 1'b1;
`ifdef SIGNED_COMB_SAT_EN
            sat_d   = overflow;
`endif
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: the delay line is reset on purpose: missing history must
            // read as zero after reset, so this storage cannot be left
            // uninitialised like a plain data RAM.
            for (int k = 0; k < DELAY; k++) begin
                dly_q[k] <= '0;
            end
            fill_q   <= '0;
            primed_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
`ifdef SIGNED_COMB_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            dly_q    <= dly_d;
            fill_q   <= fill_d;
            primed_q <= primed_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
`ifdef SIGNED_COMB_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_primed = primed_q;
`ifdef SIGNED_COMB_SAT_EN
    assign o_sat    = sat_q;
`endif

endmodule

// File: tb/tb_signed_comb.sv
// -----------------------------------------------------------------------------
// tb_signed_comb
//   Three signed_comb instances (IWIDTH=16, DELAY=1,2,3) share clock and reset.
//   A reference model computes each expected output when a sample is accepted
//   and pushes it into a per-instance queue; the queue is popped and compared
//   whenever the instance transfers an output.
// -----------------------------------------------------------------------------
module tb_signed_comb;

    localparam int IW = 16;
    localparam int NI = 3;

    typedef struct {
        int data;
        bit primed;
        bit sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [IW-1:0] in_data  [NI];
    logic                 in_valid [NI];
    logic                 dn_ready [NI];
    logic                 up_ready [NI];
    logic signed [IW:0]   out_data [NI];
    logic                 out_valid[NI];
    logic                 primed   [NI];
`ifdef SIGNED_COMB_SAT_EN
    logic                 sat      [NI];
`endif

    exp_t sb      [NI][$];
    int   hist    [NI][$];
    bit   exp_vld [NI];

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        signed_comb #(
            .IWIDTH(IW),
            .DELAY (g + 1)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_data  (in_data[g]),
            .i_valid (in_valid[g]),
            .o_ready (up_ready[g]),
            .o_data  (out_data[g]),
            .o_valid (out_valid[g]),
            .i_ready (dn_ready[g]),
`ifdef SIGNED_COMB_SAT_EN
            .o_sat   (sat[g]),
`endif
            .o_primed(primed[g])
        );
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model: difference against the sample DELAY accepts ago,
    // zero when that far back is before reset.
    function automatic exp_t model(input int k, input int x);
        exp_t e;
        int   d = k + 1;
        int   n = hist[k].size();
        int   prev = (n >= d) ? hist[k][n-d] : 0;
        e.data   = x - prev;
        e.primed = (n + 1 >= d);
        e.sat    = 1'b0;
`ifdef SIGNED_COMB_SAT_EN
        if (e.data > 32767) begin
            e.data = 32767;
            e.sat  = 1'b1;
        end else if (e.data < -32768) begin
            e.data = -32768;
            e.sat  = 1'b1;
        end
`endif
        return e;
    endfunction

    // One clock: inputs are set beforehand; sample at negedge, step past posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("ready%0d", k), int'(up_ready[k]),
                  int'(!out_valid[k] || dn_ready[k]));
            if (exp_vld[k]) begin
                check($sformatf("latency%0d", k), int'(out_valid[k]), 1);
                exp_vld[k] = 1'b0;
            end
            if (out_valid[k] && dn_ready[k]) begin
                if (sb[k].size() == 0) begin
                    check($sformatf("spurious%0d", k), int'(out_valid[k]), 0);
                end else begin
                    e = sb[k].pop_front();
                    check($sformatf("data%0d", k), int'(out_data[k]), e.data);
                    check($sformatf("primed%0d", k), int'(primed[k]), int'(e.primed));
`ifdef SIGNED_COMB_SAT_EN
                    check($sformatf("sat%0d", k), int'(sat[k]), int'(e.sat));
`endif
                end
            end
            if (in_valid[k] && up_ready[k]) begin
                sb[k].push_back(model(k, int'(in_data[k])));
                hist[k].push_back(int'(in_data[k]));
                exp_vld[k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int x);
        in_valid[k] = 1'b1;
        in_data[k]  = IW'(x);
        cycle();
        in_valid[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0;
            dn_ready[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) begin
            sb[k].delete();
            hist[k].delete();
            exp_vld[k] = 1'b0;
            check($sformatf("rst_valid%0d", k), int'(out_valid[k]), 0);
            check($sformatf("rst_primed%0d", k), int'(primed[k]), 0);
            check($sformatf("rst_data%0d", k), int'(out_data[k]), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_data[k]  = '0;
            in_valid[k] = 1'b0;
            dn_ready[k] = 1'b1;
            exp_vld[k]  = 1'b0;
        end
        idle(0);
        @(posedge clk);
        #1;
        do_reset();

        // DELAY=1 basic stream: 10, 15, -20
        send(0, 10); send(0, 25); send(0, 5);
        idle(2);

        // DELAY=3 ramp: 1, 2, 3, 3, 3, 3; primed on the third output
        for (int v = 1; v <= 6; v++) send(2, v);
        idle(2);

        // Extremes on DELAY=1: -65535 then 65535 (clamped in the saturating build)
        send(0, 32767); send(0, -32768); send(0, 32767);
        idle(2);

        // Backpressure on DELAY=1
        do_reset();
        dn_ready[0] = 1'b0;
        send(0, 7);
        in_valid[0] = 1'b1;
        in_data[0]  = 16'sd9;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_data", int'(out_data[0]), 7);
            check("stall_valid", int'(out_valid[0]), 1);
        end
        dn_ready[0] = 1'b1;
        cycle();
        in_valid[0] = 1'b0;
        check("bp_second", int'(out_data[0]), 2);
        idle(2);

        // Gaps on DELAY=2: valid 1,0,0,1,0,1 carrying 4, 6, 10 -> 4, 6, 6
        do_reset();
        send(1, 4); idle(2); send(1, 6); idle(1); send(1, 10);
        idle(2);

        // Reset mid-stream, then 8 on DELAY=1 -> 8
        for (int v = 1; v <= 5; v++) send(0, v * 100);
        check("pre_rst_valid", int'(out_valid[0]), 1);
        do_reset();
        send(0, 8);
        check("post_rst_data", int'(out_data[0]), 8);
        idle(2);

        for (int k = 0; k < NI; k++) begin
            check($sformatf("drained%0d", k), sb[k].size(), 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
